// File: rtl/weight_load_sched.sv
// Weight-load scheduler: sequences kernel-group loads and MAC runs for one layer,
// with a ready timeout, overrun detection, abort and a sticky error state.
module weight_load_sched #(
  parameter int GRP_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic [GRP_W-1:0] i_num_grp,
  input  logic             i_abort,
  input  logic             i_clr_err,
  output logic             o_load_en,
  input  logic             i_w_ready,
  output logic             o_mac_start,
  input  logic             i_mac_done,
  output logic [GRP_W-1:0] o_grp_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    MAC      = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } state_t;

  localparam logic [GRP_W-1:0] GRP_ONE = GRP_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [GRP_W-1:0] num_lat;
  logic [GRP_W-1:0] grp_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic start_ok;
  logic start_zero;
  logic last_grp;
  logic timed_out;

  logic load_en_nxt;
  logic mac_start_nxt;
  logic busy_nxt;
  logic done_nxt;
  logic err_nxt;

  assign start_ok   = i_start && (i_num_grp != '0);
  assign start_zero = i_start && (i_num_grp == '0);
  assign last_grp   = ((grp_cnt + GRP_ONE) == num_lat);
  assign timed_out  = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      o_load_en   <= 1'b0;
      o_mac_start <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_load_en   <= load_en_nxt;
      o_mac_start <= mac_start_nxt;
      o_busy      <= busy_nxt;
      o_done      <= done_nxt;
      o_err       <= err_nxt;
    end
  end

  // Abort outranks every other event in the states it applies to.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (i_abort)        state_nxt = IDLE;
        else if (i_w_ready) state_nxt = MAC;
        else if (timed_out) state_nxt = ERR;
      end
      MAC: begin
        if (i_abort) begin
          state_nxt = IDLE;
        end else if (i_mac_done) begin
          if (last_grp)       state_nxt = DONE;
          else if (i_w_ready) state_nxt = MAC;
          else                state_nxt = WAIT_RDY;
        end else if (i_w_ready) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      ERR: begin
        if (i_clr_err) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_en_nxt   = (state_nxt == WAIT_RDY) || (state_nxt == MAC);
    busy_nxt      = load_en_nxt;
    err_nxt       = (state_nxt == ERR);
    done_nxt      = (state_nxt == DONE) || ((state == IDLE) && start_zero);
    mac_start_nxt = 1'b0;
    if (!i_abort && i_w_ready) begin
      if (state == WAIT_RDY)
        mac_start_nxt = 1'b1;
      else if ((state == MAC) && i_mac_done && !last_grp)
        mac_start_nxt = 1'b1;
    end
  end

  // Group bookkeeping: the count only advances on a completed MAC run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_lat <= '0;
      grp_cnt <= '0;
    end else begin
      if ((state == IDLE) && start_ok) begin
        num_lat <= i_num_grp;
        grp_cnt <= '0;
      end else if ((state == MAC) && !i_abort && i_mac_done) begin
        grp_cnt <= grp_cnt + GRP_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if ((state == WAIT_RDY) && !i_w_ready && !i_abort) begin
      to_cnt <= to_cnt + TO_ONE;
    end else begin
      to_cnt <= '0;
    end
  end

  assign o_grp_idx = grp_cnt;

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed bench for weight_load_sched: normal layer, timeout, overrun,
// back-to-back done+ready, abort, empty layer and asynchronous reset.
module tb_weight_load_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       i_start = 1'b0;
  logic [3:0] i_num_grp = '0;
  logic       i_abort = 1'b0;
  logic       i_clr_err = 1'b0;
  logic       i_w_ready = 1'b0;
  logic       i_mac_done = 1'b0;
  logic       o_load_en;
  logic       o_mac_start;
  logic [3:0] o_grp_idx;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int tests_run = 0;
  int tests_failed = 0;

  weight_load_sched #(.GRP_W(4), .TIMEOUT(64), .TO_W(7)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_start    (i_start),
    .i_num_grp  (i_num_grp),
    .i_abort    (i_abort),
    .i_clr_err  (i_clr_err),
    .o_load_en  (o_load_en),
    .i_w_ready  (i_w_ready),
    .o_mac_start(o_mac_start),
    .i_mac_done (i_mac_done),
    .o_grp_idx  (o_grp_idx),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " load_en"},   32'(o_load_en),   32'd0);
    check_output({tag, " busy"},      32'(o_busy),      32'd0);
    check_output({tag, " mac_start"}, 32'(o_mac_start), 32'd0);
    check_output({tag, " done"},      32'(o_done),      32'd0);
    check_output({tag, " err"},       32'(o_err),       32'd0);
  endtask

  task automatic start_layer(input logic [3:0] n);
    i_start   = 1'b1;
    i_num_grp = n;
    step();
    i_start   = 1'b0;
    i_num_grp = '0;
  endtask

  initial begin
    // Reset state
    #1 rstn = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    check_output("reset grp_idx", 32'(o_grp_idx), 32'd0);
    rstn = 1'b1;
    step();
    check_idle_outputs("post-reset idle");

    // Three-group layer, one ready/done pair per group
    start_layer(4'd3);
    check_output("l3 load_en after start", 32'(o_load_en), 32'd1);
    check_output("l3 busy after start",    32'(o_busy),    32'd1);
    check_output("l3 grp_idx after start", 32'(o_grp_idx), 32'd0);
    for (int g = 0; g < 3; g++) begin
      i_w_ready = 1'b1;
      step();
      i_w_ready = 1'b0;
      check_output($sformatf("l3 g%0d mac_start pulse", g), 32'(o_mac_start), 32'd1);
      check_output($sformatf("l3 g%0d grp_idx", g),         32'(o_grp_idx),   32'(g));
      step();
      check_output($sformatf("l3 g%0d mac_start low", g),   32'(o_mac_start), 32'd0);
      i_mac_done = 1'b1;
      step();
      i_mac_done = 1'b0;
      if (g < 2) begin
        check_output($sformatf("l3 g%0d load_en", g), 32'(o_load_en), 32'd1);
        check_output($sformatf("l3 g%0d no done", g), 32'(o_done),    32'd0);
        check_output($sformatf("l3 g%0d next idx", g), 32'(o_grp_idx), 32'(g + 1));
      end else begin
        check_output("l3 done pulse",     32'(o_done),    32'd1);
        check_output("l3 load_en in DONE", 32'(o_load_en), 32'd0);
      end
    end
    step();
    check_idle_outputs("l3 back to idle");

    // Start ignored outside IDLE, then ready timeout into ERR
    start_layer(4'd2);
    i_start = 1'b1;
    i_num_grp = 4'd9;
    step();
    i_start = 1'b0;
    i_num_grp = '0;
    check_output("start ignored in WAIT_RDY", 32'(o_busy), 32'd1);
    repeat (62) step();
    check_output("timeout not yet err",  32'(o_err),     32'd0);
    check_output("timeout still loading", 32'(o_load_en), 32'd1);
    step();
    check_output("timeout err at 64",     32'(o_err),     32'd1);
    check_output("timeout load_en low",   32'(o_load_en), 32'd0);
    check_output("timeout busy low",      32'(o_busy),    32'd0);
    i_w_ready = 1'b1;
    i_mac_done = 1'b1;
    i_abort = 1'b1;
    step();
    i_w_ready = 1'b0;
    i_mac_done = 1'b0;
    i_abort = 1'b0;
    check_output("err ignores ready/done/abort", 32'(o_err),       32'd1);
    check_output("err no mac_start",             32'(o_mac_start), 32'd0);
    i_clr_err = 1'b1;
    step();
    i_clr_err = 1'b0;
    check_idle_outputs("clr_err to idle");

    // Overrun: ready while MAC still running
    start_layer(4'd2);
    i_w_ready = 1'b1;
    step();
    i_w_ready = 1'b0;
    check_output("ovr first mac_start", 32'(o_mac_start), 32'd1);
    step();
    i_w_ready = 1'b1;
    step();
    i_w_ready = 1'b0;
    check_output("ovr err",           32'(o_err),       32'd1);
    check_output("ovr no mac_start",  32'(o_mac_start), 32'd0);
    check_output("ovr load_en low",   32'(o_load_en),   32'd0);
    i_clr_err = 1'b1;
    step();
    i_clr_err = 1'b0;
    check_output("ovr cleared", 32'(o_err), 32'd0);

    // Same-cycle done+ready on a two-group layer
    start_layer(4'd2);
    i_w_ready = 1'b1;
    step();
    i_w_ready = 1'b0;
    check_output("dr g0 mac_start", 32'(o_mac_start), 32'd1);
    step();
    i_w_ready = 1'b1;
    i_mac_done = 1'b1;
    step();
    i_w_ready = 1'b0;
    i_mac_done = 1'b0;
    check_output("dr g1 mac_start",  32'(o_mac_start), 32'd1);
    check_output("dr g1 grp_idx",    32'(o_grp_idx),   32'd1);
    check_output("dr g1 still busy", 32'(o_busy),      32'd1);
    check_output("dr g1 no err",     32'(o_err),       32'd0);
    step();
    check_output("dr g1 pulse ends", 32'(o_mac_start), 32'd0);
    i_w_ready = 1'b1;
    i_mac_done = 1'b1;
    step();
    i_w_ready = 1'b0;
    i_mac_done = 1'b0;
    check_output("dr last done pulse",   32'(o_done),      32'd1);
    check_output("dr last no mac_start", 32'(o_mac_start), 32'd0);
    check_output("dr last no err",       32'(o_err),       32'd0);
    check_output("dr last load_en low",  32'(o_load_en),   32'd0);
    step();
    check_idle_outputs("dr back to idle");

    // Abort during MAC of group 1 of 4, with a coincident mac_done
    start_layer(4'd4);
    i_w_ready = 1'b1;
    step();
    i_w_ready = 1'b0;
    step();
    i_mac_done = 1'b1;
    step();
    i_mac_done = 1'b0;
    check_output("abort setup idx1", 32'(o_grp_idx), 32'd1);
    i_w_ready = 1'b1;
    step();
    i_w_ready = 1'b0;
    i_abort = 1'b1;
    i_mac_done = 1'b1;
    step();
    i_abort = 1'b0;
    i_mac_done = 1'b0;
    check_idle_outputs("abort in MAC");
    check_output("abort keeps idx", 32'(o_grp_idx), 32'd1);
    step();
    check_output("abort no late done", 32'(o_done), 32'd0);
    start_layer(4'd4);
    check_output("restart grp_idx", 32'(o_grp_idx), 32'd0);
    check_output("restart load_en", 32'(o_load_en), 32'd1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check_idle_outputs("abort in WAIT_RDY");

    // Empty layer: done pulse, never loading
    start_layer(4'd0);
    check_output("empty done pulse", 32'(o_done),    32'd1);
    check_output("empty load_en",    32'(o_load_en), 32'd0);
    check_output("empty busy",       32'(o_busy),    32'd0);
    step();
    check_idle_outputs("empty after pulse");

    // Asynchronous reset mid-WAIT_RDY
    start_layer(4'd3);
    check_output("prereset load_en", 32'(o_load_en), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_idle_outputs("async reset");
    step();
    rstn = 1'b1;
    step();
    check_idle_outputs("after reset release");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/weight_load_sched.md
WEIGHT_LOAD_SCHED -- requirements
Module: weight_load_sched

Interface
REQ-001 Parameter GRP_W, default 4, SHALL set the width of the group count and group index.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles to wait for a weight-ready pulse.
REQ-003 Parameter TO_W, default 7, SHALL set the timeout counter width, with 2^TO_W > TIMEOUT.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  one-cycle layer start request; sampled only in IDLE.
REQ-007 i_num_grp  input  GRP_W  number of kernel groups in the layer; sampled with i_start.
REQ-008 i_abort  input  1  abort the current layer.
REQ-009 i_clr_err  input  1  clear the error and leave ERR.
REQ-010 o_load_en  output  1  weight-controller load enable.
REQ-011 i_w_ready  input  1  weight-controller pulse: kernel group resident.
REQ-012 o_mac_start  output  1  one-cycle pulse starting the MAC array on the resident group.
REQ-013 i_mac_done  input  1  one-cycle pulse: MAC array finished the current group.
REQ-014 o_grp_idx  output  GRP_W  index of the group being processed.
REQ-015 o_busy  output  1  high in WAIT_RDY and MAC.
REQ-016 o_done  output  1  one-cycle layer-complete pulse.
REQ-017 o_err  output  1  error flag, high only in ERR.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_RDY, MAC, DONE and ERR, and all outputs SHALL be registered.
REQ-019 In IDLE, i_start with i_num_grp != 0 SHALL latch i_num_grp, clear grp_cnt and the timeout counter, and enter WAIT_RDY.
REQ-020 In IDLE, i_start with i_num_grp == 0 SHALL pulse o_done on the next cycle and stay in IDLE, with o_load_en held low.
REQ-021 i_start SHALL be ignored in every state except IDLE.
REQ-022 o_load_en SHALL be 1 in WAIT_RDY and MAC and 0 in all other states, rising the cycle after i_start is accepted.
REQ-023 In WAIT_RDY, the timeout counter SHALL increment every cycle.
REQ-024 In WAIT_RDY, i_w_ready SHALL clear the timeout counter, pulse o_mac_start on the next cycle and enter MAC.
REQ-025 In WAIT_RDY, if the timeout counter reaches TIMEOUT-1 with no i_w_ready, the block SHALL enter ERR.
REQ-026 In MAC, i_mac_done SHALL increment grp_cnt.
REQ-027 In MAC, on i_mac_done, if grp_cnt+1 == the latched count the block SHALL enter DONE, otherwise it SHALL enter WAIT_RDY.
REQ-028 In MAC, i_w_ready without i_mac_done in the same cycle is an overrun and SHALL cause entry to ERR.
REQ-029 In MAC, i_w_ready together with i_mac_done on a non-last group SHALL count the done, pulse o_mac_start on the next cycle and stay in MAC.
REQ-030 In MAC, i_w_ready together with i_mac_done on the last group SHALL count the done, ignore the ready and enter DONE.
REQ-031 DONE SHALL last one cycle with o_done=1 and then return to IDLE.
REQ-032 ERR SHALL hold o_err=1 and o_load_en=0, ignore i_w_ready and i_mac_done, and return to IDLE on i_clr_err.
REQ-033 i_abort in WAIT_RDY, MAC or DONE SHALL force IDLE on the next cycle with o_load_en=0 and no o_done pulse.
REQ-034 i_abort SHALL have priority over every other event in the same cycle.
REQ-035 i_abort SHALL NOT affect ERR or IDLE.
REQ-036 o_grp_idx SHALL equal grp_cnt, which is cleared on start and never wraps because it is bounded by the latched count.
REQ-037 i_mac_done in WAIT_RDY or IDLE SHALL be ignored.

Reset
REQ-038 While rstn is low, the FSM SHALL be in IDLE with all outputs, grp_cnt, the latched count and the timeout counter at 0.
REQ-039 Reset asserted mid-layer SHALL drop o_load_en immediately and asynchronously, and SHALL NOT produce an o_done pulse.

Verification
REQ-040 i_num_grp=3 with one ready/done pair per group -> o_load_en high 1 cycle after start; three o_mac_start pulses, each 1 cycle after its ready; o_grp_idx 0,1,2; one o_done pulse; o_load_en low.
REQ-041 No i_w_ready for 64 cycles after start -> o_err=1 at cycle 64 and o_load_en=0; i_clr_err -> IDLE with o_err=0.
REQ-042 i_w_ready while in MAC before i_mac_done -> ERR, with no second o_mac_start.
REQ-043 i_num_grp=2 with same-cycle done+ready on group 0 -> o_mac_start 1 cycle later and o_grp_idx=1; same-cycle done+ready on group 1 -> DONE with no extra o_mac_start.
REQ-044 i_abort during MAC of group 1 of 4 -> IDLE next cycle with o_load_en=0 and no o_done; a subsequent i_start restarts with o_grp_idx=0.
REQ-045 i_num_grp=0 start -> o_done pulse with o_load_en never high; rstn pulled low mid-WAIT_RDY -> all outputs 0 immediately.
